// File: rtl/slot_sched_pkg.sv
// slot_sched_pkg: shared state enum, id-width helper and default parameters for slot_scheduler
package slot_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_SLOT_LEN = 10;
  localparam int DEF_CW = 6;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/slot_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  always_comb begin
    onehot = '0;
    idx = '0;
    valid = 1'b0;
    j = '0;
    // scan farthest offset first so the nearest hit to ptr overwrites
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = j;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/slot_scheduler.sv
// slot_scheduler: round-robin time-slot arbiter with bounded grant length
// optional clocked assertions enabled by defining SLOT_SCHED_CHECKS_EN
module slot_scheduler
  import slot_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int SLOT_LEN = DEF_SLOT_LEN,
  parameter int CW = DEF_CW,
  localparam int IW = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rstf,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic [CW-1:0]   slot_cnt,
  output logic            expire
);
  state_t state;
  logic [IW-1:0] ptr;
  logic [NREQ-1:0] win;
  logic [IW-1:0] win_id;
  logic win_v;
  logic by_release;
  logic slot_end;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .onehot(win),
    .idx(win_id),
    .valid(win_v)
  );
  // early release outranks timeout, so expire only fires when neither release cause holds
  assign by_release = done[gnt_id] | ~req[gnt_id];
  assign slot_end = by_release | (slot_cnt == CW'(SLOT_LEN - 1));
  assign busy = |gnt;
  always_ff @(posedge clk) begin
    if (!rstf) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      slot_cnt <= '0;
      expire <= 1'b0;
      ptr <= '0;
    end else begin
      expire <= 1'b0;
      if (state == GRANT) begin
        if (slot_end) begin
          state <= HOLDOFF;
          gnt <= '0;
          gnt_id <= '0;
          slot_cnt <= '0;
          expire <= ~by_release;
          ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end else begin
        state <= win_v ? GRANT : IDLE;
        gnt <= win;
        gnt_id <= win_id;
        slot_cnt <= '0;
      end
    end
  end
`ifdef SLOT_SCHED_CHECKS_EN
  always_ff @(posedge clk) begin
    if (rstf) begin
      assert ($onehot0(gnt));
      assert (int'(slot_cnt) < SLOT_LEN);
      assert (state == GRANT || gnt == '0);
      assert (!expire || gnt == '0);
      assert (!busy || gnt == (NREQ'(1) << gnt_id));
    end
  end
`endif
endmodule

// File: tb/tb_slot_scheduler.sv
// tb_slot_scheduler: directed scenarios plus randomized traffic against an event-level reference model
module tb_slot_scheduler;
  localparam int NREQ = 4;
  localparam int SLOT_LEN = 10;
  localparam int CW = 6;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rstf = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] done = '0;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0] gnt_id;
  logic busy;
  logic [CW-1:0] slot_cnt;
  logic expire;
  int total = 0;
  int bad = 0;
  int m_cur = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_exp = 1'b0;

  slot_scheduler #(.NREQ(NREQ), .SLOT_LEN(SLOT_LEN), .CW(CW)) dut (
    .clk(clk),
    .rstf(rstf),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .busy(busy),
    .slot_cnt(slot_cnt),
    .expire(expire)
  );

  always #5 clk = ~clk;

  // owner/age model: who holds the resource, for how long, and who is next in line
  function automatic void model_tick();
    bit ended;
    if (!rstf) begin
      m_cur = -1;
      m_cnt = 0;
      m_ptr = 0;
      m_exp = 1'b0;
    end else if (m_cur >= 0) begin
      ended = done[m_cur] || !req[m_cur] || (m_cnt == SLOT_LEN - 1);
      if (ended) begin
        m_exp = !done[m_cur] && req[m_cur];
        m_ptr = (m_cur + 1) % NREQ;
        m_cur = -1;
        m_cnt = 0;
      end else begin
        m_cnt++;
        m_exp = 1'b0;
      end
    end else begin
      m_exp = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (m_cur < 0 && req[(m_ptr + k) % NREQ]) begin
          m_cur = (m_ptr + k) % NREQ;
          m_cnt = 0;
        end
      end
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [NREQ-1:0] g;
    logic [IW-1:0] id;
    g = (m_cur >= 0) ? NREQ'(1 << m_cur) : '0;
    id = (m_cur >= 0) ? IW'(m_cur) : '0;
    return {g, id, (m_cur >= 0), CW'(m_cnt), m_exp};
  endfunction

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r);
    rstf = 1'b0;
    req = r;
    done = '0;
    step();
    rstf = 1'b1;
  endtask

  task automatic test_reset();
    rstf = 1'b0;
    req = '1;
    done = '0;
    step();
    step();
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (gnt_id !== '0) begin bad++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (slot_cnt !== '0) begin bad++; $display("FAIL reset_slot_cnt: got %0d want 0", slot_cnt); end
    total++; if (expire !== 1'b0) begin bad++; $display("FAIL reset_expire: got %b want 0", expire); end
    rstf = 1'b1;
  endtask

  task automatic test_single();
    do_reset('0);
    req = 4'b0001;
    step();
    total++; if (gnt !== 4'b0001 || slot_cnt !== '0) begin bad++; $display("FAIL single_first: gnt=%b cnt=%0d want 0001/0", gnt, slot_cnt); end
    for (int c = 1; c < SLOT_LEN; c++) begin
      step();
      total++; if (gnt !== 4'b0001 || int'(slot_cnt) != c || expire !== 1'b0) begin bad++; $display("FAIL single_hold: gnt=%b cnt=%0d exp=%b want 0001/%0d/0", gnt, slot_cnt, expire, c); end
    end
    step();
    total++; if (gnt !== '0 || expire !== 1'b1) begin bad++; $display("FAIL single_expire: gnt=%b exp=%b want 0000/1", gnt, expire); end
    step();
    total++; if (gnt !== 4'b0001 || expire !== 1'b0 || slot_cnt !== '0) begin bad++; $display("FAIL single_regrant: gnt=%b exp=%b cnt=%0d want 0001/0/0", gnt, expire, slot_cnt); end
    for (int c = 0; c < 12; c++) begin
      step();
      total++; if ({gnt, gnt_id, busy, slot_cnt, expire} !== exp_vec()) begin bad++; $display("FAIL single_model: got %h want %h", {gnt, gnt_id, busy, slot_cnt, expire}, exp_vec()); end
    end
  endtask

  task automatic test_round_robin();
    do_reset(4'b1111);
    for (int g = 0; g < 5; g++) begin
      step();
      total++; if (gnt !== NREQ'(1 << (g % NREQ)) || int'(gnt_id) != g % NREQ) begin bad++; $display("FAIL rr_order: gnt=%b id=%0d want id %0d", gnt, gnt_id, g % NREQ); end
      for (int c = 1; c < SLOT_LEN; c++) begin
        step();
        total++; if (busy !== 1'b1 || int'(slot_cnt) != c) begin bad++; $display("FAIL rr_hold: busy=%b cnt=%0d want 1/%0d", busy, slot_cnt, c); end
      end
      step();
      total++; if (gnt !== '0 || expire !== 1'b1) begin bad++; $display("FAIL rr_gap: gnt=%b exp=%b want 0000/1", gnt, expire); end
    end
  endtask

  task automatic test_early_done();
    do_reset('0);
    req = 4'b0100;
    step();
    for (int c = 1; c <= 3; c++) step();
    total++; if (gnt !== 4'b0100 || slot_cnt !== 6'd3) begin bad++; $display("FAIL early_setup: gnt=%b cnt=%0d want 0100/3", gnt, slot_cnt); end
    done = 4'b0100;
    req = 4'b1111;
    step();
    done = '0;
    total++; if (gnt !== '0 || expire !== 1'b0) begin bad++; $display("FAIL early_drop: gnt=%b exp=%b want 0000/0", gnt, expire); end
    step();
    total++; if (gnt_id !== 2'd3 || gnt !== 4'b1000) begin bad++; $display("FAIL early_ptr: id=%0d gnt=%b want 3/1000", gnt_id, gnt); end
  endtask

  task automatic test_done_at_timeout();
    do_reset('0);
    req = 4'b0010;
    step();
    for (int c = 1; c < SLOT_LEN; c++) step();
    total++; if (slot_cnt !== 6'd9 || gnt !== 4'b0010) begin bad++; $display("FAIL dto_setup: cnt=%0d gnt=%b want 9/0010", slot_cnt, gnt); end
    done = 4'b0010;
    step();
    done = '0;
    total++; if (gnt !== '0 || expire !== 1'b0) begin bad++; $display("FAIL dto_noexpire: gnt=%b exp=%b want 0000/0", gnt, expire); end
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    req = 4'b0010;
    step();
    for (int c = 1; c <= 5; c++) step();
    total++; if (slot_cnt !== 6'd5) begin bad++; $display("FAIL rmid_setup: cnt=%0d want 5", slot_cnt); end
    rstf = 1'b0;
    step();
    total++; if ({gnt, gnt_id, busy, slot_cnt, expire} !== 14'd0) begin bad++; $display("FAIL rmid_clear: got %h want 0", {gnt, gnt_id, busy, slot_cnt, expire}); end
    rstf = 1'b1;
    step();
    total++; if (gnt !== 4'b0010 || gnt_id !== 2'd1 || expire !== 1'b0) begin bad++; $display("FAIL rmid_regrant: gnt=%b id=%0d exp=%b want 0010/1/0", gnt, gnt_id, expire); end
  endtask

  task automatic test_ignored();
    do_reset('0);
    req = 4'b0001;
    step();
    for (int c = 1; c < SLOT_LEN; c++) begin
      req = {3'($urandom), 1'b1};
      done = {3'($urandom), 1'b0};
      step();
      total++; if (gnt !== 4'b0001 || int'(slot_cnt) != c) begin bad++; $display("FAIL ignored_hold: gnt=%b cnt=%0d want 0001/%0d", gnt, slot_cnt, c); end
    end
    req = 4'b0001;
    done = '0;
    step();
    total++; if (gnt !== '0 || expire !== 1'b1) begin bad++; $display("FAIL ignored_end: gnt=%b exp=%b want 0000/1", gnt, expire); end
  endtask

  task automatic test_random();
    do_reset('0);
    for (int c = 0; c < 800; c++) begin
      req = NREQ'($urandom);
      done = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : '0;
      rstf = ($urandom_range(0, 80) != 0);
      step();
      total++; if ({gnt, gnt_id, busy, slot_cnt, expire} !== exp_vec()) begin bad++; $display("FAIL random_model: cycle %0d got %h want %h", c, {gnt, gnt_id, busy, slot_cnt, expire}, exp_vec()); end
    end
    rstf = 1'b1;
    for (int c = 0; c < 200; c++) begin
      req = ($urandom_range(0, 9) == 0) ? NREQ'($urandom) : req | NREQ'($urandom);
      done = '0;
      step();
      total++; if ({gnt, gnt_id, busy, slot_cnt, expire} !== exp_vec()) begin bad++; $display("FAIL random_long: cycle %0d got %h want %h", c, {gnt, gnt_id, busy, slot_cnt, expire}, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_done();
    test_done_at_timeout();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slot_scheduler.md
# slot_scheduler

Time-slot scheduler sharing one modulo slot counter among NREQ requesters. Grants are round-robin and one-hot. A grant lasts until the requester signals done, drops its request, or the slot counter reaches SLOT_LEN-1. It sits in front of any shared resource that must be held by exactly one client for a bounded number of cycles.

## Interface
- NREQ, 4: number of requesters, 2..8
- SLOT_LEN, 10: maximum grant length in cycles, 1..2**CW
- CW, 6: slot counter width
- clk  in  1  clock, all logic on posedge
- rstf  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request level
- done  in  NREQ  per-requester early release; only the bit of the granted id is sampled
- gnt  out  NREQ  one-hot-or-zero grant, registered
- gnt_id  out  $clog2(NREQ)  index of current grant, 0 when idle
- busy  out  1  equals |gnt
- slot_cnt  out  CW  cycles elapsed in current slot, 0 when idle
- expire  out  1  one-cycle pulse when a slot ends by timeout

## Operation
- FSM states: IDLE, GRANT, HOLDOFF. Reset state is IDLE.
- Reset values: gnt=0, gnt_id=0, busy=0, slot_cnt=0, expire=0, round-robin pointer ptr=0.
- IDLE: if any req bit is set, pick the first set bit at or after ptr, wrapping modulo NREQ. Load gnt and gnt_id, set slot_cnt=0, go to GRANT. Otherwise stay.
- GRANT: slot_cnt increments by 1 each cycle. The slot ends if any of these holds in the current cycle:
  - done[gnt_id]
  - !req[gnt_id]
  - slot_cnt==SLOT_LEN-1
- On slot end (next edge): gnt=0, slot_cnt=0, ptr=(gnt_id+1) mod NREQ, state goes to HOLDOFF.
  - expire=1 for that one cycle only if the end is by timeout with done[gnt_id]=0 and req[gnt_id]=1.
  - Early release takes priority over timeout.
- HOLDOFF: exactly one dead cycle with gnt=0. Arbitration happens in this cycle, same as IDLE: go to GRANT with the new winner if any req is set, else go to IDLE.
- Requests and done bits from non-granted ids are ignored while in GRANT.
- slot_cnt never exceeds SLOT_LEN-1. There is no counter wrap beyond slot end.
- A requester holding req continuously is re-granted only after every other active requester has had a turn.

## Timing
- Grant latency: req rises in cycle N while in IDLE, gnt is high from cycle N+1.
- Timeout slot: gnt is high for exactly SLOT_LEN cycles. expire rises in the same cycle gnt falls.
- Early release: done or req-drop sampled in cycle M drops gnt in cycle M+1.
- Back-to-back grants are separated by exactly one cycle of gnt=0.
- SLOT_LEN=1: every grant lasts one cycle, and expire pulses after each grant unless done is high in the grant cycle.
- Reset mid-grant: rstf low at an edge clears all outputs and ptr at that edge. No expire pulse is produced.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SLOT_SCHED_CHECKS_EN defined: enables clocked immediate assertions, gated by rstf high:
  - gnt is one-hot-or-zero
  - slot_cnt < SLOT_LEN
  - gnt==0 in IDLE and HOLDOFF
  - expire implies gnt==0
  - gnt_id matches gnt when busy
- SLOT_SCHED_CHECKS_EN not defined: no assertion logic. Functional behaviour is identical.
- Intended for both the BMC flow and simulation.

## Structure
- Package slot_sched_pkg holds:
  - the state enum (IDLE, GRANT, HOLDOFF)
  - the function for the id width
  - default parameter constants
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req and ptr.
  - Outputs: one-hot winner, winner index, valid.
  - Reused by the FSM in IDLE and in HOLDOFF.

## Test plan
All scenarios use NREQ=4, SLOT_LEN=10.
- Single requester: req=0001 held. gnt=0001 for 10 cycles, then expire pulse, then 1 cycle gap, then re-grant for another 10 cycles.
- Round-robin: req=1111 held from reset. Grant order is 0,1,2,3,0. Each grant is 10 cycles with a 1-cycle gap between grants.
- Early done: req=0100, done[2] pulsed when slot_cnt=3. gnt drops on the next cycle, expire stays 0, ptr becomes 3.
- Simultaneous done and timeout: done[id] high at slot_cnt=9. gnt drops on the next cycle and expire=0.
- Reset mid-grant: rstf low at slot_cnt=5. The next cycle shows all outputs 0 and state IDLE; with req=0010 still held, the first grant after release goes to id 1.
- Ignored bits: done and req toggled on non-granted ids during a grant. The grant is unaffected and slot_cnt runs to 9.
